// File: rtl/line_fill_engine.sv
// Cache line refill: captures a missed line address, runs one fixed-length word burst
// on the memory bus, assembles the line and queues it with its index/tag for install.
module line_fill_engine #(
    parameter int FIFO_DEPTH = 2,
    parameter int BEATS      = 16,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_req,
    input  logic [25:0]           req_addr,
    output logic                  busy,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  fifo_pop,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [7:0]            fifo_addr,
    output logic [17:0]           fill_tag,
    output logic [LINE_WIDTH-1:0] read_line_data
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST  = BW'(BEATS - 1);
    localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, BURST, PUSH} state_e;

    state_e                state_q;
    logic                  busy_q;
    logic                  mem_req_q;
    logic [31:0]           mem_addr_q;
    logic [25:0]           addr_q;
    logic [BW-1:0]         beat_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic [25:0]           ent_addr_q [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] ent_line_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;

    logic          dup, accept, capture, push, pop;
    logic [PW-1:0] off;

    // An address already sitting in the queue is fetched and waiting for install.
    always_comb begin
        dup = 1'b0;
        off = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (ent_addr_q[i] == req_addr))
                dup = 1'b1;
        end
    end

    assign accept  = (state_q == IDLE) && is_req && (count_q < DEPTH) && !dup;
    // The beat arriving alongside the ack is part of the line.
    assign capture = mem_rvalid && ((state_q == BURST) || ((state_q == REQ) && mem_ack));
    assign push    = (state_q == PUSH);
    assign pop     = fifo_pop && (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            line_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    addr_q     <= req_addr;
                    mem_addr_q <= {req_addr, 6'b0};
                    beat_q     <= '0;
                    mem_req_q  <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= REQ;
                end
                REQ: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    state_q   <= (capture && beat_q == LAST) ? PUSH : BURST;
                end
                BURST: if (capture && beat_q == LAST) state_q <= PUSH;
                PUSH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (capture) begin
                line_q[32*beat_q +: 32] <= mem_rdata;
                beat_q                  <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= addr_q;
            ent_line_q[wr_ptr_q] <= line_q;
        end
    end

    assign busy           = busy_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign fifo_empty     = (count_q == '0);
    assign fifo_full      = (count_q == DEPTH);
    assign fifo_addr      = ent_addr_q[rd_ptr_q][7:0];
    assign fill_tag       = ent_addr_q[rd_ptr_q][25:8];
    assign read_line_data = ent_line_q[rd_ptr_q];
endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine: a queue-level reference of fills and the
// completed-line FIFO is compared every cycle, plus literal expectations per scenario.
module tb_line_fill_engine;
    localparam int DEPTH = 2;
    localparam int BEATS = 16;

    logic         clk = 1'b0, reset = 1'b0;
    logic         is_req = 1'b0, mem_ack = 1'b0, mem_rvalid = 1'b0, fifo_pop = 1'b0;
    logic [25:0]  req_addr = '0;
    logic [31:0]  mem_rdata = '0;
    logic         busy, mem_req, fifo_empty, fifo_full;
    logic [31:0]  mem_addr;
    logic [7:0]   fifo_addr;
    logic [17:0]  fill_tag;
    logic [511:0] read_line_data;

    line_fill_engine #(.FIFO_DEPTH(DEPTH), .BEATS(BEATS), .LINE_WIDTH(512)) dut (
        .clk(clk), .reset(reset), .is_req(is_req), .req_addr(req_addr),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fifo_pop(fifo_pop),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_addr(fifo_addr),
        .fill_tag(fill_tag), .read_line_data(read_line_data)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: completed lines as a queue, the in-flight fill as a word list.
    typedef struct packed { logic [25:0] addr; logic [511:0] line; } ent_t;
    ent_t        mq[$];
    ent_t        m_ent;
    logic [31:0] m_words[$];
    logic [25:0] m_addr;
    logic [31:0] m_mem_addr;
    bit          m_active, m_acked, m_push, m_pop;

    function automatic bit m_has(input logic [25:0] a);
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [511:0] pack_words();
        logic [511:0] l = '0;
        for (int k = 0; k < BEATS; k++) l[32*k +: 32] = m_words[k];
        return l;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete(); m_words.delete();
            m_active = 0; m_acked = 0; m_push = 0; m_mem_addr = '0;
        end else begin
            m_pop = fifo_pop && (mq.size() > 0);
            if (m_push) begin
                m_ent.addr = m_addr; m_ent.line = pack_words();
                mq.push_back(m_ent);
                m_push = 0;
            end else if (m_active) begin
                if (m_acked || mem_ack) begin
                    if (mem_rvalid) m_words.push_back(mem_rdata);
                    m_acked = 1;
                end
                if (m_words.size() == BEATS) begin m_active = 0; m_push = 1; end
            end else if (is_req && mq.size() < DEPTH && !m_has(req_addr)) begin
                m_active = 1; m_acked = 0; m_addr = req_addr; m_words.delete();
                m_mem_addr = {req_addr, 6'b0};
            end
            if (m_pop) void'(mq.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy", busy, m_active || m_push);
            chk("mem_req", mem_req, m_active && !m_acked);
            chk("mem_addr", mem_addr, m_mem_addr);
            chk("fifo_empty", fifo_empty, mq.size() == 0);
            chk("fifo_full", fifo_full, mq.size() == DEPTH);
            if (mq.size() > 0) begin
                chk("head_index", fifo_addr, mq[0].addr[7:0]);
                chk("head_tag", fill_tag, mq[0].addr[25:8]);
                chk("head_line", read_line_data, mq[0].line);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        int c = 0;
        while (!mem_req && c < 40) begin @(negedge clk); c++; end
        chk(nm, mem_req, 1'b1);
    endtask

    task automatic ack(input int delay, input bit with_beat, input logic [31:0] base);
        repeat (delay) @(negedge clk);
        mem_ack = 1'b1;
        if (with_beat) begin mem_rvalid = 1'b1; mem_rdata = base; end
        @(negedge clk);
        mem_ack = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic beats(input logic [31:0] base, input int from, input int to, input int maxgap);
        for (int k = from; k <= to; k++) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = base + 32'(k);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic fill(input logic [25:0] a, input logic [31:0] base, input int delay,
                        input bit ack_beat, input int maxgap, input bit keep_req);
        is_req = 1'b1; req_addr = a;
        wait_req("fill_mem_req");
        if (!keep_req) is_req = 1'b0;
        ack(delay, ack_beat, base);
        beats(base, ack_beat ? 1 : 0, BEATS - 1, maxgap);
    endtask

    task automatic pop1();
        fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk_en = 1'b1;
        tick();
        reset = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);

        // Single fill; is_req is held for the duplicate test that follows.
        is_req = 1'b1; req_addr = 26'h00002C5;
        wait_req("t1_mem_req");
        chk("t1_mem_addr", mem_addr, 32'h0000_B140);
        ack(2, 1'b0, 32'h1000_0000);
        beats(32'h1000_0000, 0, 15, 0);
        chk("t1_empty_in_push", fifo_empty, 1'b1);
        tick();
        chk("t1_empty_after", fifo_empty, 1'b0);
        chk("t1_index", fifo_addr, 8'hC5);
        chk("t1_tag", fill_tag, 18'h2);
        chk("t1_word0", read_line_data[31:0], 32'h1000_0000);
        chk("t1_word15", read_line_data[511:480], 32'h1000_000F);

        // Duplicate suppression, then pop releases the same address.
        for (int i = 0; i < 8; i++) begin tick(); chk("t2_no_dup_req", mem_req, 1'b0); end
        pop1();
        chk("t2_req_same_cycle", mem_req, 1'b0);
        tick();
        chk("t2_req_after_pop", mem_req, 1'b1);
        is_req = 1'b0;
        ack(0, 1'b0, 32'h2000_0000);
        beats(32'h2000_0000, 0, 15, 0);
        tick();
        chk("t2_refill_index", fifo_addr, 8'hC5);
        pop1();
        chk("t2_empty", fifo_empty, 1'b1);

        // Full FIFO blocks a third request until a pop.
        fill(26'h0001234, 32'h3000_0000, 1, 1'b0, 0, 1'b0); tick();
        fill(26'h000ABCD, 32'h3100_0000, 0, 1'b0, 0, 1'b0); tick();
        chk("t3_full", fifo_full, 1'b1);
        is_req = 1'b1; req_addr = 26'h3FFFFFF;
        tick(5);
        chk("t3_blocked", mem_req, 1'b0);
        chk("t3_head_a", fifo_addr, 8'h34);
        pop1();
        tick();
        chk("t3_req_after_pop", mem_req, 1'b1);
        is_req = 1'b0;
        ack(1, 1'b0, 32'h3200_0000);
        beats(32'h3200_0000, 0, 15, 2);
        tick();
        chk("t3_full_again", fifo_full, 1'b1);
        pop1(); pop1();
        chk("t3_empty", fifo_empty, 1'b1);

        // Random beat gaps with a beat in the ack cycle.
        fill(26'h1555555, 32'hA5A5_0000, 0, 1'b1, 3, 1'b0);
        tick();
        chk("t4_word0", read_line_data[31:0], 32'hA5A5_0000);
        chk("t4_word8", read_line_data[287:256], 32'hA5A5_0008);
        chk("t4_word15", read_line_data[511:480], 32'hA5A5_000F);
        chk("t4_one_entry", fifo_full, 1'b0);

        // Pop on the PUSH edge: count stays 1, head becomes the new line.
        fill(26'h0000077, 32'h5000_0000, 1, 1'b0, 0, 1'b0);
        fifo_pop = 1'b1; tick(); fifo_pop = 1'b0;
        chk("t5_empty", fifo_empty, 1'b0);
        chk("t5_full", fifo_full, 1'b0);
        chk("t5_head", fifo_addr, 8'h77);
        pop1();
        chk("t5_drained", fifo_empty, 1'b1);

        // Reset after beat 7, then stray beats must be ignored.
        is_req = 1'b1; req_addr = 26'h2ABCDEF;
        wait_req("t6_mem_req");
        is_req = 1'b0;
        ack(0, 1'b0, 32'h6000_0000);
        beats(32'h6000_0000, 0, 7, 0);
        reset = 1'b0;
        tick();
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b1;
        beats(32'h6000_0000, 8, 16, 0);
        tick();
        chk("t6_busy", busy, 1'b0);
        chk("t6_empty", fifo_empty, 1'b1);
        fill(26'h00003A1, 32'h7000_0000, 1, 1'b0, 1, 1'b0);
        tick();
        chk("t6_new_index", fifo_addr, 8'hA1);
        chk("t6_new_tag", fill_tag, 18'h3);
        chk("t6_new_word0", read_line_data[31:0], 32'h7000_0000);
        pop1();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_fill_engine.md
Name: line_fill_engine

Overview:
- Refill stage directly downstream of the data cache's miss request and upstream of its line-fill FIFO port.
- Captures a missed line address, issues a fixed-length 16-beat word burst read to the memory bus, and assembles the beats into one 512-bit line.
- Queues each finished line with its index and tag in a small FIFO, which the cache pops to install the line.

Parameters:
- FIFO_DEPTH, 2: number of completed lines buffered; must be a power of two, at least 2.
- BEATS, 16: 32-bit words per line.
- LINE_WIDTH, 512: line width in bits; equals BEATS*32.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- is_req  input  1  miss request level from the cache.
- req_addr  input  26  line address, byte address [31:6].
- busy  output  1  high while a fill is in flight (state not IDLE).
- mem_req  output  1  burst read request.
- mem_addr  output  32  burst start address, {captured req_addr, 6'b0}.
- mem_ack  input  1  memory accepts the request.
- mem_rvalid  input  1  one read beat valid.
- mem_rdata  input  32  read beat data.
- fifo_pop  input  1  cache consumes the head entry.
- fifo_empty  output  1  no completed line available.
- fifo_full  output  1  FIFO_DEPTH entries held.
- fifo_addr  output  8  head entry line index (req_addr[7:0]).
- fill_tag  output  18  head entry tag (req_addr[25:8]).
- read_line_data  output  512  head entry line data.

Behaviour:
- Reset values (asynchronous, while reset is low): state IDLE; busy 0; mem_req 0; mem_addr 0; beat counter 0; line buffer 0; FIFO pointers and count 0; fifo_empty 1; fifo_full 0. Entry contents are don't-care.
- fifo_addr, fill_tag and read_line_data are combinational reads of the head entry; they are don't-care while fifo_empty is high.
- State machine: IDLE -> REQ -> BURST -> PUSH -> IDLE.
- IDLE:
  - Accept a request when is_req=1, FIFO count < FIFO_DEPTH, and req_addr matches no occupied FIFO entry. A matching entry means the line is already fetched and awaiting install.
  - On accept: latch req_addr; clear the beat counter; move to REQ.
  - Otherwise stay in IDLE.
- REQ: mem_req=1; mem_addr holds the latched address. On mem_ack=1, drop mem_req on the next edge and move to BURST. A mem_rvalid in the same cycle as mem_ack is legal and is captured.
- BURST (also captures during the REQ ack cycle):
  - Each mem_rvalid writes mem_rdata to line bits [32k+31:32k], where k is the beat counter; k then increments.
  - The beat with k = BEATS-1 moves the state to PUSH.
  - No timeout; gaps between beats are allowed.
- PUSH: write {latched addr, line buffer} into the FIFO tail in one cycle, then move to IDLE.
  - Space is guaranteed by the IDLE acceptance check, since only one fill is in flight.
- Latency:
  - is_req seen at edge E0 -> mem_req high after E0.
  - Last beat at edge En -> entry written at En+1 -> fifo_empty low after En+1.
  - Next accept is possible at En+2.
- mem_rvalid in IDLE or PUSH is ignored.
- Pop: fifo_pop=1 at an edge with fifo_empty=0 removes the head. fifo_pop while empty is ignored with no pointer change.
- Simultaneous push and pop: both take effect and the count is unchanged. fifo_full is never asserted after such a cycle unless it was already asserted.
- Pointers wrap modulo FIFO_DEPTH. fifo_full = (count == FIFO_DEPTH); fifo_empty = (count == 0).
- is_req dropping after acceptance does not abort the fill.
- Reset mid-burst: everything returns to reset values immediately. Beats arriving after reset release are ignored because the state is IDLE.

Test Plan:
- Single fill:
  - Stimulus: reset, then is_req=1 with req_addr=26'h0000_2C5; memory acks after 2 cycles and returns 16 consecutive beats 32'h1000_0000+k.
  - Required: mem_addr=32'h0000_B140; after the last beat, fifo_empty=0 one edge later; fifo_addr=8'hC5; fill_tag=18'h2; read_line_data[31:0]=32'h1000_0000 and [511:480]=32'h1000_000F.
- Duplicate suppression: hold is_req=1 with the same address after the entry is pushed and unpopped -> no second mem_req. Pop -> a new mem_req is issued on the following cycle.
- Full FIFO: complete 2 fills without popping -> fifo_full=1. A third is_req stays pending with mem_req=0 until one fifo_pop, after which mem_req rises.
- Beat gaps and ack-cycle data: beats with random 0-3 cycle gaps, plus rvalid in the mem_ack cycle -> all 16 words land in correct positions and exactly one entry is pushed.
- Simultaneous push and pop: with count=1, pop on the same edge as PUSH -> count stays 1 and the head becomes the new line.
- Reset mid-burst: assert reset after beat 7, release, then send 9 stray beats -> busy=0, fifo_empty=1, no push; a fresh request completes correctly.
